// File: rtl/dshot_pkg.sv
// dshot_pkg: shared DShot frame constants, FSM encoding and CRC helper
package dshot_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} state_t;
    localparam int FRAME_W = 16;
    localparam int THROTTLE_W = 11;
    localparam int CMD_THRESH = 48;
    function automatic logic [3:0] crc4(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction
endpackage

// File: rtl/dshot_crc4.sv
// dshot_crc4: combinational 4-bit DShot checksum of the 12-bit payload
module dshot_crc4 import dshot_pkg::*; (
    input  logic [11:0] data,
    output logic [3:0]  crc
);
    assign crc = crc4(data);
endmodule

// File: rtl/dshot_frame_ctrl.sv
// dshot_frame_ctrl: DShot frame receiver with CRC check, arming and failsafe
module dshot_frame_ctrl import dshot_pkg::*; #(
    parameter int BIT_TICKS      = 16,
    parameter int ONE_THRESH     = 9,
    parameter int MIN_HIGH       = 2,
    parameter int GAP_TICKS      = 32,
    parameter int ARM_FRAMES     = 10,
    parameter int FAILSAFE_TICKS = 4096
) (
    input  logic                  quarterClockOut,
    input  logic                  reset,
    input  logic                  inSignal,
    output logic [THROTTLE_W-1:0] setSpeed,
    output logic                  telemetry,
    output logic                  armed,
    output logic                  RCValid,
    output logic                  processing,
    output logic                  validSpeed,
    output logic                  frameStrobe,
    output logic                  crcError
);
    localparam int CW = $clog2(2 * BIT_TICKS + GAP_TICKS + 2);
    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int FW = $clog2(FAILSAFE_TICKS + 1);
    localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH);
    localparam logic [CW-1:0] ONE_C = CW'(ONE_THRESH);
    localparam logic [CW-1:0] GAP_C = CW'(GAP_TICKS);
    localparam logic [CW-1:0] PERIOD_C = CW'(2 * BIT_TICKS);
    localparam logic [AW-1:0] ARM_C = AW'(ARM_FRAMES);
    localparam logic [FW-1:0] FS_C = FW'(FAILSAFE_TICKS);
    localparam logic [4:0] FRAME_C = 5'(FRAME_W);

    state_t state;
    logic [CW-1:0] highCnt, lowCnt, periodCnt;
    logic [CW-1:0] highNext, lowNext, periodNext;
    logic [4:0] bitCnt;
    logic [FRAME_W-1:0] frame;
    logic [AW-1:0] armCnt;
    logic [FW-1:0] failCnt;
    logic [3:0] crc;
    logic crcOk, accept, expired;

    assign highNext = highCnt + CW'(1);
    assign lowNext = lowCnt + CW'(1);
    assign periodNext = periodCnt + CW'(1);

    dshot_crc4 crcUnit (
        .data(frame[15:4]),
        .crc (crc)
    );

    assign crcOk = crc == frame[3:0];
    assign accept = state == CHECK && crcOk;
    assign expired = failCnt == FS_C;

    // Bit-level receiver: measures high/low times and assembles the 16-bit frame
    always_ff @(posedge quarterClockOut) begin
        if (reset) begin
            state <= IDLE;
            processing <= 1'b0;
            highCnt <= '0;
            lowCnt <= '0;
            periodCnt <= '0;
            bitCnt <= '0;
            frame <= '0;
        end else begin
            case (state)
                IDLE: if (inSignal) begin
                    state <= HIGH;
                    processing <= 1'b1;
                    bitCnt <= '0;
                    frame <= '0;
                    highCnt <= '0;
                    periodCnt <= '0;
                end
                HIGH: if (periodNext > PERIOD_C) begin
                    state <= IDLE;
                    processing <= 1'b0;
                end else if (!inSignal) begin
                    if (highNext >= MIN_HIGH_C) begin
                        state <= LOW;
                        frame <= {frame[FRAME_W-2:0], highNext >= ONE_C};
                        bitCnt <= bitCnt + 5'd1;
                        lowCnt <= '0;
                        periodCnt <= periodNext;
                    end else begin
                        state <= IDLE;
                        processing <= 1'b0;
                    end
                end else begin
                    highCnt <= highNext;
                    periodCnt <= periodNext;
                end
                LOW: if (bitCnt == FRAME_C) begin
                    state <= CHECK;
                end else if (periodNext > PERIOD_C) begin
                    state <= IDLE;
                    processing <= 1'b0;
                end else if (inSignal) begin
                    state <= HIGH;
                    highCnt <= '0;
                    periodCnt <= '0;
                end else if (lowNext >= GAP_C) begin
                    state <= IDLE;
                    processing <= 1'b0;
                end else begin
                    lowCnt <= lowNext;
                    periodCnt <= periodNext;
                end
                CHECK: begin
                    state <= IDLE;
                    processing <= 1'b0;
                end
            endcase
        end
    end

    // Frame acceptance, arming and failsafe; an accept overrides a same-cycle expiry
    always_ff @(posedge quarterClockOut) begin
        if (reset) begin
            setSpeed <= '0;
            telemetry <= 1'b0;
            armed <= 1'b0;
            RCValid <= 1'b0;
            validSpeed <= 1'b0;
            frameStrobe <= 1'b0;
            crcError <= 1'b0;
            armCnt <= '0;
            failCnt <= '0;
        end else begin
            frameStrobe <= accept;
            crcError <= state == CHECK && !crcOk;
            validSpeed <= armed && setSpeed >= THROTTLE_W'(CMD_THRESH);
            if (accept) begin
                setSpeed <= frame[15:5];
                telemetry <= frame[4];
                failCnt <= '0;
                RCValid <= 1'b1;
                if (frame[15:5] != '0) begin
                    armCnt <= '0;
                end else if (!armed && armCnt != ARM_C) begin
                    armCnt <= armCnt + AW'(1);
                    if (armCnt + AW'(1) == ARM_C) armed <= 1'b1;
                end
            end else begin
                if (state == CHECK) armCnt <= '0;
                if (expired) begin
                    RCValid <= 1'b0;
                    armed <= 1'b0;
                    armCnt <= '0;
                    setSpeed <= '0;
                end else begin
                    failCnt <= failCnt + FW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_dshot_frame_ctrl.sv
// tb_dshot_frame_ctrl: self-checking bench with frame vectors, corner sequences and a random frame model
module tb_dshot_frame_ctrl;
    logic quarterClockOut = 1'b0;
    logic reset = 1'b1;
    logic inSignal = 1'b0;
    logic [10:0] setSpeed;
    logic telemetry, armed, RCValid, processing, validSpeed, frameStrobe, crcError;
    int tests = 0, fails = 0, cyc = 0, lastFall = 0, strobes = 0, errs = 0;

    typedef struct {
        int val; bit tlm; bit bad;
        int speed; bit tlmo; bit arm; bit vld; int nstb; int nerr;
    } vec_t;
    vec_t vecs[$];

    dshot_frame_ctrl dut (
        .quarterClockOut(quarterClockOut),
        .reset(reset),
        .inSignal(inSignal),
        .setSpeed(setSpeed),
        .telemetry(telemetry),
        .armed(armed),
        .RCValid(RCValid),
        .processing(processing),
        .validSpeed(validSpeed),
        .frameStrobe(frameStrobe),
        .crcError(crcError)
    );

    always #5 quarterClockOut = ~quarterClockOut;

    always @(posedge quarterClockOut) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge quarterClockOut) begin
        if (!reset && (frameStrobe || crcError)) begin
            if (frameStrobe) strobes++;
            if (crcError) errs++;
            check("strobe latency", cyc - lastFall, 3);
        end
    end

    task automatic drive(input logic v, input int n);
        inSignal = v;
        repeat (n) @(negedge quarterClockOut);
    endtask

    function automatic logic [15:0] mkframe(input int val, input bit tlm, input bit bad);
        int v = val * 2 + int'(tlm);
        int c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        if (bad) c = c ^ 5;
        return 16'(v * 16 + c);
    endfunction

    task automatic send_frame(input logic [15:0] f, input bit jitter);
        for (int i = 15; i >= 0; i--) begin
            int h = f[i] ? (jitter ? int'($urandom_range(14, 9)) : 12) : (jitter ? int'($urandom_range(8, 2)) : 6);
            int l = jitter ? int'($urandom_range(12, 3)) : 16 - h;
            drive(1'b1, h);
            if (i == 0) lastFall = cyc;
            drive(1'b0, l);
        end
        drive(1'b0, 8);
    endtask

    initial begin
        int s0, e0, val, mSpeed, mArm;
        bit tlm, bad, mTlm, mArmed, mRC;
        logic [15:0] f;
        for (int i = 0; i < 10; i++) vecs.push_back('{0, 0, 0, 0, 0, i == 9, 0, 1, 0});
        vecs.push_back('{1046, 0, 0, 1046, 0, 1, 1, 1, 0});
        vecs.push_back('{1046, 0, 1, 1046, 0, 1, 1, 0, 1});
        vecs.push_back('{47, 1, 0, 47, 1, 1, 0, 1, 0});
        vecs.push_back('{48, 0, 0, 48, 0, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 1, 0, 1, 0});
        vecs.push_back('{2047, 1, 1, 0, 1, 1, 0, 0, 1});
        vecs.push_back('{1046, 0, 0, 1046, 0, 1, 1, 1, 0});

        repeat (3) @(negedge quarterClockOut);
        check("reset setSpeed", setSpeed, 0);
        check("reset telemetry", telemetry, 0);
        check("reset armed", armed, 0);
        check("reset RCValid", RCValid, 0);
        check("reset processing", processing, 0);
        check("reset validSpeed", validSpeed, 0);
        check("reset frameStrobe", frameStrobe, 0);
        check("reset crcError", crcError, 0);
        reset = 1'b0;
        drive(1'b0, 4);

        f = mkframe(500, 0, 0);
        for (int i = 15; i >= 8; i--) begin
            drive(1'b1, f[i] ? 12 : 6);
            drive(1'b0, f[i] ? 4 : 10);
        end
        reset = 1'b1;
        @(negedge quarterClockOut);
        check("reset mid-frame processing", processing, 0);
        reset = 1'b0;
        drive(1'b0, 40);
        check("reset mid-frame strobes", strobes, 0);
        check("reset mid-frame setSpeed", setSpeed, 0);

        foreach (vecs[i]) begin
            s0 = strobes;
            e0 = errs;
            send_frame(mkframe(vecs[i].val, vecs[i].tlm, vecs[i].bad), 1'b0);
            check($sformatf("vec%0d setSpeed", i), setSpeed, vecs[i].speed);
            check($sformatf("vec%0d telemetry", i), telemetry, vecs[i].tlmo);
            check($sformatf("vec%0d armed", i), armed, vecs[i].arm);
            check($sformatf("vec%0d validSpeed", i), validSpeed, vecs[i].vld);
            check($sformatf("vec%0d RCValid", i), RCValid, 1);
            check($sformatf("vec%0d strobes", i), strobes - s0, vecs[i].nstb);
            check($sformatf("vec%0d crcErrors", i), errs - e0, vecs[i].nerr);
            check($sformatf("vec%0d processing", i), processing, 0);
        end

        s0 = strobes;
        f = mkframe(300, 0, 0);
        for (int i = 15; i >= 8; i--) begin
            drive(1'b1, f[i] ? 12 : 6);
            drive(1'b0, f[i] ? 4 : 10);
        end
        drive(1'b0, 40);
        check("gap processing", processing, 0);
        check("gap strobes", strobes - s0, 0);
        check("gap setSpeed", setSpeed, 1046);
        send_frame(f, 1'b0);
        check("after gap setSpeed", setSpeed, 300);
        check("after gap strobes", strobes - s0, 1);

        s0 = strobes;
        e0 = errs;
        inSignal = 1'b1;
        @(negedge quarterClockOut);
        check("glitch processing high", processing, 1);
        inSignal = 1'b0;
        @(negedge quarterClockOut);
        check("glitch processing low", processing, 0);
        drive(1'b0, 20);
        check("glitch strobes", strobes - s0, 0);
        check("glitch crcErrors", errs - e0, 0);
        check("glitch setSpeed", setSpeed, 300);

        drive(1'b0, 4000);
        check("pre-failsafe armed", armed, 1);
        check("pre-failsafe RCValid", RCValid, 1);
        drive(1'b0, 200);
        check("failsafe RCValid", RCValid, 0);
        check("failsafe armed", armed, 0);
        check("failsafe setSpeed", setSpeed, 0);
        check("failsafe validSpeed", validSpeed, 0);

        mSpeed = 0;
        mTlm = 0;
        mArm = 0;
        mArmed = 0;
        mRC = 0;
        for (int i = 0; i < 40; i++) begin
            val = (i < 14 || $urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(2047, 0));
            tlm = 1'($urandom_range(1, 0));
            bad = i >= 12 && $urandom_range(7, 0) == 0;
            s0 = strobes;
            e0 = errs;
            send_frame(mkframe(val, tlm, bad), 1'b1);
            if (bad) begin
                mArm = 0;
            end else begin
                mSpeed = val;
                mTlm = tlm;
                mRC = 1;
                if (val != 0) mArm = 0;
                else if (!mArmed) begin
                    mArm = mArm + 1;
                    if (mArm >= 10) mArmed = 1;
                end
            end
            check($sformatf("rnd%0d setSpeed", i), setSpeed, mSpeed);
            check($sformatf("rnd%0d telemetry", i), telemetry, mTlm);
            check($sformatf("rnd%0d armed", i), armed, mArmed);
            check($sformatf("rnd%0d RCValid", i), RCValid, mRC);
            check($sformatf("rnd%0d validSpeed", i), validSpeed, mArmed && mSpeed >= 48);
            check($sformatf("rnd%0d strobes", i), strobes - s0, bad ? 0 : 1);
            check($sformatf("rnd%0d crcErrors", i), errs - e0, bad ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
